// File: rtl/spi_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_master
// Purpose  : SPI frame initiator that shifts N bits MSB-first, captures N bits
//            from MISO and ends each frame with a load pulse to the slave.
// Revision : 1.0  initial release
// ============================================================================
module spi_master #(
  parameter int N   = 16,
  parameter int DIV = 4
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         start,
  input  logic [N-1:0] DI,
  input  logic         MISO,
  output logic         sclk,
  output logic         MOSI,
  output logic         load,
  output logic [N-1:0] DO,
  output logic         busy,
  output logic         done
);

  localparam int HW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TAIL  = 2'd2,
    LOAD  = 2'd3
  } state_t;

  state_t          state_q;
  logic [HW-1:0]   half_q;
  logic [BW-1:0]   bit_q;
  // The MSB goes straight to MOSI at acceptance, so only N-1 bits wait here.
  logic [N-2:0]    tx_q;
  logic [N-1:0]    rx_q;
  logic [N-1:0]    do_q;
  logic            sclk_q;
  logic            mosi_q;
  logic            load_q;
  logic            busy_q;
  logic            done_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      half_q  <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      do_q    <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            tx_q    <= DI[N-2:0];
            mosi_q  <= DI[N-1];
            busy_q  <= 1'b1;
            half_q  <= '0;
            bit_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (half_q == HALF_LAST) begin
            half_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
              rx_q   <= {rx_q[N-2:0], MISO};
            end else begin
              sclk_q <= 1'b0;
              // After the last bit MOSI keeps bit 0 through the tail.
              if (bit_q == BIT_LAST) begin
                state_q <= TAIL;
              end else begin
                mosi_q <= tx_q[N-2];
                tx_q   <= tx_q << 1;
                bit_q  <= bit_q + BW'(1);
              end
            end
          end else begin
            half_q <= half_q + HW'(1);
          end
        end
        TAIL: begin
          if (half_q == HALF_LAST) begin
            half_q  <= '0;
            load_q  <= 1'b1;
            state_q <= LOAD;
          end else begin
            half_q <= half_q + HW'(1);
          end
        end
        LOAD: begin
          if (half_q == HALF_LAST) begin
            half_q  <= '0;
            load_q  <= 1'b0;
            mosi_q  <= 1'b0;
            do_q    <= rx_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            half_q <= half_q + HW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sclk = sclk_q;
  assign MOSI = mosi_q;
  assign load = load_q;
  assign DO   = do_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_master
// Purpose  : Self-checking bench for spi_master with behavioural SPI slaves.
// Revision : 1.0  initial release
// ============================================================================
module tb_spi_master;

  localparam int N    = 16;
  localparam int DIV  = 4;
  localparam int LAT  = 2 * N * DIV + 2 * DIV;
  localparam int N2   = 8;
  localparam int DIV2 = 2;
  localparam int LAT2 = 2 * N2 * DIV2 + 2 * DIV2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         clr_n, start, miso, sclk, mosi, load, busy, done;
  logic [N-1:0] di, dout;

  spi_master #(.N(N), .DIV(DIV)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .DI(di), .MISO(miso),
    .sclk(sclk), .MOSI(mosi), .load(load), .DO(dout), .busy(busy), .done(done)
  );

  logic          start2, miso2, sclk2, mosi2, load2, busy2, done2;
  logic [N2-1:0] di2, dout2;

  spi_master #(.N(N2), .DIV(DIV2)) dut2 (
    .clk(clk), .clr_n(clr_n), .start(start2), .DI(di2), .MISO(miso2),
    .sclk(sclk2), .MOSI(mosi2), .load(load2), .DO(dout2), .busy(busy2), .done(done2)
  );

  // Slave for dut: shifts out on sclk fall, samples on sclk rise, latches on load.
  logic [N-1:0] s_tx = '0, s_rx = '0, s_do = '0, s_di = '0;
  logic loopback = 1'b0, echo = 1'b0, pre = 1'b0;
  assign miso = loopback ? mosi : s_tx[N-1];
  always @(posedge sclk) s_rx <= {s_rx[N-2:0], mosi};
  always @(negedge sclk or posedge load or posedge pre) begin
    if (pre) s_tx <= s_di;
    else if (load) begin
      s_do <= s_rx;
      s_tx <= echo ? s_rx : s_di;
    end else s_tx <= s_tx << 1;
  end

  logic [N2-1:0] s2_tx = '0, s2_rx = '0, s2_do = '0, s2_di = '0;
  logic pre2 = 1'b0;
  assign miso2 = s2_tx[N2-1];
  always @(posedge sclk2) s2_rx <= {s2_rx[N2-2:0], mosi2};
  always @(negedge sclk2 or posedge load2 or posedge pre2) begin
    if (pre2) s2_tx <= s2_di;
    else if (load2) begin
      s2_do <= s2_rx;
      s2_tx <= s2_di;
    end else s2_tx <= s2_tx << 1;
  end

  int           rises = 0, loadcyc = 0, donecnt = 0, rises2 = 0;
  logic [N-1:0] cap = '0;
  longint       t_last2 = 0, t_prev2 = 0;
  always @(posedge sclk) begin
    rises <= rises + 1;
    cap   <= {cap[N-2:0], mosi};
  end
  always @(posedge sclk2) begin
    rises2  <= rises2 + 1;
    t_prev2 <= t_last2;
    t_last2 <= $time;
  end
  always @(posedge clk) begin
    if (load) loadcyc <= loadcyc + 1;
    if (done) donecnt <= donecnt + 1;
  end

  int npass = 0, ntot = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic preload(input logic [N-1:0] w);
    s_di = w;
    pre  = 1'b1;
    #1 pre = 1'b0;
  endtask

  // lat = cycles from the accepting edge to the done sample; bcyc = busy-high samples.
  task automatic run_frame(input logic [N-1:0] d, output int lat, output int bcyc, output bit ok);
    lat = 0; bcyc = 0; ok = 1'b0;
    @(negedge clk);
    di = d;
    start = 1'b1;
    for (int i = 0; i < LAT + 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) bcyc++;
      if (done) begin
        ok = 1'b1;
        break;
      end
      lat++;
    end
  endtask

  typedef struct {
    logic [N-1:0] di;
    logic [N-1:0] sw;
    bit           lb;
    logic [N-1:0] exp;
  } vec_t;

  initial begin
    vec_t         tv[4];
    int           lat, bcyc, r0, l0, d0, nd, cyc, last;
    bit           ok;
    logic [N-1:0] rd, rs;
    logic [N-1:0] exp_m[3];

    tv[0] = '{16'hA5C3, 16'h3C5A, 1'b0, 16'h3C5A};
    tv[1] = '{16'h8001, 16'h0000, 1'b1, 16'h8001};
    tv[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFF};
    tv[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0000};

    clr_n = 1'b0; start = 1'b0; di = '0; start2 = 1'b0; di2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {28'd0, sclk, mosi, load, busy}, 32'd0);
    chk("rst_done_do", {done, dout}, '0);
    clr_n = 1'b1;

    for (int k = 0; k < 4; k++) begin
      loopback = tv[k].lb;
      preload(tv[k].sw);
      r0 = rises; l0 = loadcyc;
      run_frame(tv[k].di, lat, bcyc, ok);
      chk($sformatf("v%0d_done", k), {31'd0, ok}, 32'd1);
      chk($sformatf("v%0d_lat", k), lat, LAT);
      chk($sformatf("v%0d_busy", k), bcyc, LAT);
      chk($sformatf("v%0d_do", k), dout, tv[k].exp);
      chk($sformatf("v%0d_rises", k), rises - r0, N);
      chk($sformatf("v%0d_mosi", k), cap, tv[k].di);
      chk($sformatf("v%0d_loadw", k), loadcyc - l0, DIV);
      if (!tv[k].lb) chk($sformatf("v%0d_sdo", k), s_do, tv[k].di);
    end
    loopback = 1'b0;

    // Random words: master must return the slave's word, slave must get DI.
    for (int k = 0; k < 6; k++) begin
      rd = N'($urandom);
      rs = N'($urandom);
      preload(rs);
      r0 = rises;
      run_frame(rd, lat, bcyc, ok);
      chk($sformatf("r%0d_do", k), dout, rs);
      chk($sformatf("r%0d_sdo", k), s_do, rd);
      chk($sformatf("r%0d_rises", k), rises - r0, N);
      chk($sformatf("r%0d_lat", k), {31'd0, ok} + lat, LAT + 1);
    end

    // Back-to-back frames with start held; the slave echoes the prior frame.
    echo = 1'b1;
    preload(16'hBEEF);
    exp_m[0] = 16'hBEEF; exp_m[1] = 16'h0001; exp_m[2] = 16'h0002;
    @(negedge clk);
    di = 16'h0001; start = 1'b1;
    nd = 0; cyc = 0; last = 0;
    for (int i = 0; i < 3 * (LAT + 1) + 30 && nd < 3; i++) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        chk($sformatf("b2b%0d_do", nd), dout, exp_m[nd]);
        chk($sformatf("b2b%0d_sdo", nd), s_do, N'(nd + 1));
        chk($sformatf("b2b%0d_idle", nd), {31'd0, busy}, 32'd0);
        if (nd > 0) chk($sformatf("b2b%0d_space", nd), cyc - last, LAT + 1);
        last = cyc;
        nd++;
        di = N'(nd + 1);
        if (nd < 3) begin
          @(negedge clk);
          cyc++;
          chk($sformatf("b2b%0d_restart", nd), {31'd0, busy}, 32'd1);
          if (nd == 2) start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("b2b_count", nd, 3);
    repeat (10) @(negedge clk);
    chk("b2b_stop", {31'd0, busy}, 32'd0);
    echo = 1'b0;

    // start during an active frame must be ignored.
    preload(16'h1357);
    d0 = donecnt; r0 = rises;
    @(negedge clk);
    di = 16'h2468; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (39) @(negedge clk);
    di = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("mid_busy", {31'd0, busy}, 32'd1);
    ok = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    chk("mid_done", {31'd0, ok}, 32'd1);
    chk("mid_do", dout, 16'h1357);
    repeat (20) @(negedge clk);
    chk("mid_ndone", donecnt - d0, 1);
    chk("mid_rises", rises - r0, N);
    chk("mid_sdo", s_do, 16'h2468);
    chk("mid_idle", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of bit 7.
    preload(16'h1111);
    r0 = rises;
    @(negedge clk);
    di = 16'hABCD; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      if (rises - r0 == 7) begin ok = 1'b1; break; end
    end
    chk("rstm_reach", {31'd0, ok}, 32'd1);
    #2 clr_n = 1'b0;
    #1;
    chk("rstm_outs", {28'd0, sclk, mosi, load, busy}, 32'd0);
    chk("rstm_do", dout, 16'h0000);
    d0 = donecnt;
    repeat (5) @(negedge clk);
    clr_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstm_nodone", donecnt - d0, 0);
    run_frame(16'h1234, lat, bcyc, ok);
    chk("rstm_next_done", {31'd0, ok}, 32'd1);
    chk("rstm_next_lat", lat, LAT);
    chk("rstm_next_sdo", s_do, 16'h1234);

    // Narrow instance: N=8, DIV=2.
    s2_di = 8'h69;
    pre2 = 1'b1;
    #1 pre2 = 1'b0;
    r0 = rises2;
    @(negedge clk);
    di2 = 8'h96; start2 = 1'b1;
    bcyc = 0; ok = 1'b0;
    for (int i = 0; i < LAT2 + 20; i++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (busy2) bcyc++;
      if (done2) begin ok = 1'b1; break; end
    end
    chk("n8_done", {31'd0, ok}, 32'd1);
    chk("n8_busy", bcyc, LAT2);
    chk("n8_do", {24'd0, dout2}, 32'h69);
    chk("n8_sdo", {24'd0, s2_do}, 32'h96);
    chk("n8_rises", rises2 - r0, N2);
    chk("n8_period", 32'(t_last2 - t_prev2), 32'd40);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
`default_nettype wire
